// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared encodings, widths and helpers for the pong match controller
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam int TIME_W  = 6;

  typedef enum logic [1:0] {
    ST_P1_SERVE = 2'd0,
    ST_P2_SERVE = 2'd1,
    ST_PLAYING  = 2'd2,
    ST_END      = 2'd3
  } state_e;

  localparam logic DIR_TO_P2 = 1'b0;
  localparam logic DIR_TO_P1 = 1'b1;

  // Scores stop at the top of their range instead of wrapping back to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/btn_edge_latch.sv
// rtl/btn_edge_latch.sv - OR of a player's two buttons, rising-edge detect, sticky until cleared
module btn_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic btn_a_i,
  input  logic btn_b_i,
  input  logic clr_i,
  output logic pending_o
);

  logic btn_now;
  logic rise;
  logic prev_q;
  logic pend_q;
  logic pend_d;

  assign btn_now = btn_a_i | btn_b_i;
  assign rise    = btn_now & ~prev_q;

  // A fresh edge beats a clear in the same cycle so it survives to the next tick.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d = 1'b0;
    if (rise)  pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      prev_q <= btn_now;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - match sequencer: serve/play/end state, scores, serve countdown, launch
// Optional DEUCE_RULE_EN: a win also needs a two-point lead (a saturated scorer scoring again wins).
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned LEFT_LIMIT    = 150,
  parameter int unsigned RIGHT_LIMIT   = 490,
  parameter int unsigned WIN_SCORE     = 7,
  parameter int unsigned SERVE_TIMEOUT = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               p1l,
  input  logic               p1r,
  input  logic               p2l,
  input  logic               p2r,
  input  logic               restart,
  input  logic [9:0]         ball_x,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [TIME_W-1:0]  time_cnt,
  output logic               launch,
  output logic               launch_dir,
  output logic               winner
);

  localparam logic [9:0]         LEFT_L  = 10'(LEFT_LIMIT);
  localparam logic [9:0]         RIGHT_L = 10'(RIGHT_LIMIT);
  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
  localparam logic [TIME_W-1:0]  SERVE_T = TIME_W'(SERVE_TIMEOUT);

  state_e             state_q;
  logic [SCORE_W-1:0] p1_score_q;
  logic [SCORE_W-1:0] p2_score_q;
  logic [TIME_W-1:0]  time_cnt_q;
  logic               launch_q;
  logic               launch_dir_q;
  logic               winner_q;

  logic               p1_pend;
  logic               p2_pend;
  logic               pend_clr;
  logic [SCORE_W-1:0] p1_score_d;
  logic [SCORE_W-1:0] p2_score_d;
  logic               p1_wins;
  logic               p2_wins;

  // Every tick consumes whatever edges were latched; restart out of END flushes them too.
  assign pend_clr = tick | ((state_q == ST_END) & restart);

  btn_edge_latch u_p1_btn (
    .clk       (clk),
    .reset     (reset),
    .btn_a_i   (p1l),
    .btn_b_i   (p1r),
    .clr_i     (pend_clr),
    .pending_o (p1_pend)
  );

  btn_edge_latch u_p2_btn (
    .clk       (clk),
    .reset     (reset),
    .btn_a_i   (p2l),
    .btn_b_i   (p2r),
    .clr_i     (pend_clr),
    .pending_o (p2_pend)
  );

  assign p1_score_d = sat_inc(p1_score_q);
  assign p2_score_d = sat_inc(p2_score_q);

`ifdef DEUCE_RULE_EN
  assign p1_wins = (p1_score_d >= WIN_S) &&
                   (({1'b0, p1_score_d} >= ({1'b0, p2_score_q} + 5'd2)) || (p1_score_q == '1));
  assign p2_wins = (p2_score_d >= WIN_S) &&
                   (({1'b0, p2_score_d} >= ({1'b0, p1_score_q} + 5'd2)) || (p2_score_q == '1));
`else
  assign p1_wins = (p1_score_d >= WIN_S);
  assign p2_wins = (p2_score_d >= WIN_S);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_P1_SERVE;
      p1_score_q   <= '0;
      p2_score_q   <= '0;
      time_cnt_q   <= SERVE_T;
      launch_q     <= 1'b0;
      launch_dir_q <= DIR_TO_P2;
      winner_q     <= 1'b0;
    end else begin
      launch_q <= 1'b0;
      case (state_q)
        ST_P1_SERVE: begin
          if (tick) begin
            if (p1_pend || (time_cnt_q <= TIME_W'(1))) begin
              launch_q     <= 1'b1;
              launch_dir_q <= DIR_TO_P2;
              state_q      <= ST_PLAYING;
              time_cnt_q   <= '0;
            end else begin
              time_cnt_q <= time_cnt_q - TIME_W'(1);
            end
          end
        end
        ST_P2_SERVE: begin
          if (tick) begin
            if (p2_pend || (time_cnt_q <= TIME_W'(1))) begin
              launch_q     <= 1'b1;
              launch_dir_q <= DIR_TO_P1;
              state_q      <= ST_PLAYING;
              time_cnt_q   <= '0;
            end else begin
              time_cnt_q <= time_cnt_q - TIME_W'(1);
            end
          end
        end
        ST_PLAYING: begin
          // Right-side miss is checked first so overlapping limits still resolve deterministically.
          if (tick) begin
            if (ball_x > RIGHT_L) begin
              p1_score_q <= p1_score_d;
              if (p1_wins) begin
                state_q  <= ST_END;
                winner_q <= 1'b0;
              end else begin
                state_q    <= ST_P2_SERVE;
                time_cnt_q <= SERVE_T;
              end
            end else if (ball_x < LEFT_L) begin
              p2_score_q <= p2_score_d;
              if (p2_wins) begin
                state_q  <= ST_END;
                winner_q <= 1'b1;
              end else begin
                state_q    <= ST_P1_SERVE;
                time_cnt_q <= SERVE_T;
              end
            end
          end
        end
        ST_END: begin
          if (restart) begin
            p1_score_q <= '0;
            p2_score_q <= '0;
            state_q    <= ST_P1_SERVE;
            time_cnt_q <= SERVE_T;
          end
        end
        default: begin
          state_q <= ST_P1_SERVE;
        end
      endcase
    end
  end

  assign game_state = state_q;
  assign p1_score   = p1_score_q;
  assign p2_score   = p2_score_q;
  assign time_cnt   = time_cnt_q;
  assign launch     = launch_q;
  assign launch_dir = launch_dir_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - directed self-checking bench for pong_match_ctrl (default build)
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       p1l, p1r, p2l, p2r;
  logic       restart;
  logic [9:0] ball_x;
  logic [1:0] game_state;
  logic [3:0] p1_score, p2_score;
  logic [5:0] time_cnt;
  logic       launch, launch_dir, winner;

  int tests_run    = 0;
  int tests_failed = 0;

  pong_match_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .p1l        (p1l),
    .p1r        (p1r),
    .p2l        (p2l),
    .p2r        (p2r),
    .restart    (restart),
    .ball_x     (ball_x),
    .game_state (game_state),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .time_cnt   (time_cnt),
    .launch     (launch),
    .launch_dir (launch_dir),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulse_p1l();
    @(negedge clk);
    p1l = 1'b1;
    @(negedge clk);
    p1l = 1'b0;
  endtask

  task automatic pulse_p2l();
    @(negedge clk);
    p2l = 1'b1;
    @(negedge clk);
    p2l = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; restart = 1'b0;
    p1l = 1'b0; p1r = 1'b1; p2l = 1'b0; p2r = 1'b0;
    ball_x = 10'd320;
    repeat (2) @(negedge clk);
    check("rst_state", game_state, 0);
    check("rst_p1", p1_score, 0);
    check("rst_p2", p2_score, 0);
    check("rst_time", time_cnt, 50);
    check("rst_launch", launch, 0);
    check("rst_winner", winner, 0);
    check("rst_dir", launch_dir, 0);
    reset = 1'b0;

    // p1r held through reset: no serve, countdown only
    do_tick();
    check("held_launch", launch, 0);
    check("held_state", game_state, 0);
    check("held_time", time_cnt, 49);
    @(negedge clk); p1r = 1'b0;
    @(negedge clk);

    repeat (3) begin @(negedge clk); p1l = 1'b1; end
    @(negedge clk); p1l = 1'b0;
    do_tick();
    check("srv1_launch", launch, 1);
    check("srv1_dir", launch_dir, 0);
    check("srv1_state", game_state, 2);
    check("srv1_time", time_cnt, 0);
    @(negedge clk);
    check("srv1_pulse_end", launch, 0);

    // rally outcomes and limit boundaries
    ball_x = 10'd491;
    do_tick();
    check("rmiss_p1", p1_score, 1);
    check("rmiss_state", game_state, 1);
    check("rmiss_time", time_cnt, 50);
    check("rmiss_launch", launch, 0);
    ball_x = 10'd320;
    @(negedge clk); p2r = 1'b1;
    @(negedge clk); p2r = 1'b0;
    do_tick();
    check("srv2_launch", launch, 1);
    check("srv2_dir", launch_dir, 1);
    check("srv2_state", game_state, 2);
    ball_x = 10'd490;
    do_tick();
    check("edge490_state", game_state, 2);
    check("edge490_p1", p1_score, 1);
    ball_x = 10'd150;
    do_tick();
    check("edge150_state", game_state, 2);
    check("edge150_p2", p2_score, 0);
    ball_x = 10'd149;
    do_tick();
    check("lmiss_p2", p2_score, 1);
    check("lmiss_state", game_state, 0);
    check("lmiss_time", time_cnt, 50);

    // automatic serve after the countdown; p2 presses ignored in p1 serve
    ball_x = 10'd320;
    pulse_p2l();
    do_tick();
    check("auto_t1_time", time_cnt, 49);
    check("auto_t1_state", game_state, 0);
    check("auto_t1_launch", launch, 0);
    for (int i = 2; i <= 49; i++) begin
      do_tick();
      check("auto_count", time_cnt, 32'(50 - i));
    end
    check("auto_t49_state", game_state, 0);
    do_tick();
    check("auto_launch", launch, 1);
    check("auto_dir", launch_dir, 0);
    check("auto_state", game_state, 2);
    check("auto_time", time_cnt, 0);

    // p1 keeps missing until p2 reaches 7
    ball_x = 10'd100;
    do_tick();
    check("miss2_p2", p2_score, 2);
    for (int s = 3; s <= 7; s++) begin
      pulse_p1l();
      do_tick();
      do_tick();
      check("miss_p2", p2_score, 32'(s));
    end
    check("end_state", game_state, 3);
    check("end_winner", winner, 1);
    check("end_p1", p1_score, 1);
    check("end_time", time_cnt, 0);
    ball_x = 10'd600;
    do_tick();
    pulse_p1l();
    do_tick();
    ball_x = 10'd20;
    do_tick();
    check("hold_p1", p1_score, 1);
    check("hold_p2", p2_score, 7);
    check("hold_state", game_state, 3);
    check("hold_winner", winner, 1);
    check("hold_launch", launch, 0);
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    check("rs_p1", p1_score, 0);
    check("rs_p2", p2_score, 0);
    check("rs_state", game_state, 0);
    check("rs_time", time_cnt, 50);

    // asynchronous reset in the middle of a rally
    ball_x = 10'd320;
    pulse_p1l();
    do_tick();
    ball_x = 10'd491;
    do_tick();
    check("pre_p1", p1_score, 1);
    ball_x = 10'd320;
    pulse_p2l();
    pulse_p2l();
    @(negedge clk); p2r = 1'b1;
    @(negedge clk); p2r = 1'b0;
    do_tick();
    check("pre_launch", launch, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_state", game_state, 0);
    check("arst_p1", p1_score, 0);
    check("arst_time", time_cnt, 50);
    check("arst_launch", launch, 0);
    check("arst_dir", launch_dir, 0);
    @(negedge clk); reset = 1'b0;
    do_tick();
    check("post_time", time_cnt, 49);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
